csr_trap_ctrl: RTL
==================

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 SHALL have parameter XLEN, default 64, data width of all CSR values/PCs.
REQ-003 SHALL have ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- csr_req_valid  in  1  CSR instruction at commit
- csr_op  in  2  01 RW, 10 RS, 11 RC, 00 no-op
- csr_addr  in  12  target CSR
- csr_src  in  XLEN  rs1/zimm operand
- exc_valid  in  1  exception/interrupt at commit
- exc_cause  in  XLEN  mcause value (bit XLEN-1 = interrupt)
- exc_pc  in  XLEN  faulting PC
- exc_tval  in  XLEN  trap value
- mret_valid  in  1  mret at commit
- mstatus_in, mtvec_in, mepc_in  in  XLEN each  current CSR state from csrfile
- csr_raddr  out  12  read address to csrfile
- csr_rdata  in  XLEN  csrfile combinational read data
- csr_wen  out  1  write strobe to csrfile
- csr_wa  out  12  write address
- csr_wd  out  XLEN  write data
- busy  out  1  state != IDLE; upstream holds requests
- rd_valid  out  1  old CSR value ready for rd
- rd_data  out  XLEN  old CSR value
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  XLEN  redirect target

Function
REQ-004 SHALL implement FSM states IDLE, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_TVAL, TRAP_STATUS, MRET_STATUS.
REQ-005 SHALL accept requests only in IDLE; priority exc_valid > mret_valid > csr_req_valid; lower-priority requests in the same cycle are dropped.
REQ-006 SHALL drive csr_raddr = csr_addr combinationally in IDLE, 0 otherwise.
REQ-007 On CSR accept: register old = csr_rdata, addr, and new = src (RW), old|src (RS), old&~src (RC); next state CSR_WR.
REQ-008 In CSR_WR (one cycle): rd_valid=1, rd_data=old; csr_wen=1, wa=addr, wd=new, except wen=0 when op is RS/RC with src==0 or op==00; then IDLE.
REQ-009 On exception accept: snapshot exc_pc, exc_cause, exc_tval, mstatus_in, mtvec_in; sequence TRAP_EPC -> TRAP_CAUSE -> TRAP_TVAL -> TRAP_STATUS -> IDLE, one cycle each.
REQ-010 TRAP_EPC writes mepc = pc with bits[1:0]=0; TRAP_CAUSE writes mcause = cause; TRAP_TVAL writes mtval = tval.
REQ-011 TRAP_STATUS writes mstatus with MPIE(bit7)=old MIE(bit3), MIE=0, MPP[12:11]=2'b11, other bits unchanged; same cycle redirect_valid=1.
REQ-012 Trap target: mtvec[1:0]==0 or cause non-interrupt -> {mtvec[XLEN-1:2],2'b00}; mtvec[1:0]==1 and interrupt -> base + 4*cause[5:0]; mtvec[1:0] in {2,3} treated as direct.
REQ-013 On mret accept: snapshot mstatus_in, mepc_in; MRET_STATUS writes mstatus MIE=MPIE, MPIE=1, MPP=0; same cycle redirect_valid=1, redirect_pc=mepc snapshot; then IDLE.
REQ-014 At most one CSR write per cycle; csr_wen, rd_valid, redirect_valid SHALL be 0 in all cycles not listed above.
REQ-015 Requests arriving while busy=1 SHALL be ignored (no queueing).
REQ-016 Additions in REQ-012 wrap modulo 2^XLEN.

Reset
REQ-017 On reset: state=IDLE, all snapshot registers 0, all outputs 0 (busy=0, csr_wen=0, rd_valid=0, redirect_valid=0, data/address outputs 0).
REQ-018 Reset mid-sequence SHALL abort it: no further writes or redirect issued the following cycle.

Verification
REQ-019 CSRRW mscratch(0x340), rdata=0x11, src=0x22 -> next cycle rd_data=0x11, wen=1, wa=0x340, wd=0x22; busy high 1 cycle.
REQ-020 CSRRS mstatus(0x300), src=0 -> rd_valid=1, csr_wen=0; CSRRC with old=0xFF, src=0x0F -> wd=0xF0.
REQ-021 exc_valid cause=2, pc=0x8000_0102, tval=0xDEAD, mstatus=0x8, mtvec=0x8000_1000 -> writes 0x341=0x8000_0100, 0x342=2, 0x343=0xDEAD, 0x300=0x1880 on 4 consecutive cycles; redirect_pc=0x8000_1000 on 4th.
REQ-022 Interrupt cause=(1<<63)|7, mtvec=0x8000_1001 -> redirect_pc=0x8000_101C.
REQ-023 exc_valid, mret_valid, csr_req_valid same cycle -> only trap sequence; csr_req during busy ignored; mret with mstatus=0x1880, mepc=0x8000_0200 -> wd=0x88, redirect_pc=0x8000_0200.
REQ-024 reset asserted in TRAP_CAUSE -> next cycle csr_wen=0, busy=0, redirect_valid never asserted.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : csr_trap_ctrl
//  Purpose  : Commit-stage sequencer for CSR read-modify-write, trap entry
//             (mepc/mcause/mtval/mstatus) and mret, driving one csrfile port.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csr_req_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_src,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_wen,
    output logic [11:0]     csr_wa,
    output logic [XLEN-1:0] csr_wd,
    output logic            busy,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [2:0] c_idle        = 3'd0;
    localparam logic [2:0] c_csr_wr      = 3'd1;
    localparam logic [2:0] c_trap_epc    = 3'd2;
    localparam logic [2:0] c_trap_cause  = 3'd3;
    localparam logic [2:0] c_trap_tval   = 3'd4;
    localparam logic [2:0] c_trap_status = 3'd5;
    localparam logic [2:0] c_mret_status = 3'd6;

    localparam logic [11:0] c_addr_mstatus = 12'h300;
    localparam logic [11:0] c_addr_mepc    = 12'h341;
    localparam logic [11:0] c_addr_mcause  = 12'h342;
    localparam logic [11:0] c_addr_mtval   = 12'h343;

    localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-2){1'b1}}, 2'b00};

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;

    logic [XLEN-1:0] r_old;
    logic [XLEN-1:0] r_new;
    logic [11:0]     r_addr;
    logic            r_wen_ok;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;

    logic            w_idle;
    logic            w_take_exc;
    logic            w_take_mret;
    logic            w_take_csr;
    logic [XLEN-1:0] w_csr_new;
    logic            w_csr_wen_ok;
    logic [XLEN-1:0] w_tvec_base;
    logic            w_vectored;
    logic [XLEN-1:0] w_trap_target;
    logic [XLEN-1:0] w_trap_status;
    logic [XLEN-1:0] w_mret_status;

    // Exceptions win over mret, mret over CSR ops; losers are simply dropped.
    assign w_idle      = (r_state == c_idle);
    assign w_take_exc  = w_idle && exc_valid;
    assign w_take_mret = w_idle && !exc_valid && mret_valid;
    assign w_take_csr  = w_idle && !exc_valid && !mret_valid && csr_req_valid;

    // Set/clear with a zero operand must not write (no side effects on read-only CSRs).
    assign w_csr_wen_ok = (csr_op == 2'b01) || (csr_op[1] && (csr_src != '0));

    always_comb begin
        w_csr_new = csr_rdata;
        case (csr_op)
            2'b01:   w_csr_new = csr_src;
            2'b10:   w_csr_new = csr_rdata | csr_src;
            2'b11:   w_csr_new = csr_rdata & ~csr_src;
            default: w_csr_new = csr_rdata;
        endcase
    end

    assign w_tvec_base   = r_mtvec & c_align_mask;
    assign w_vectored    = (r_mtvec[1:0] == 2'b01) && r_cause[XLEN-1];
    assign w_trap_target = w_vectored
                         ? w_tvec_base + {{(XLEN-8){1'b0}}, r_cause[5:0], 2'b00}
                         : w_tvec_base;

    always_comb begin
        w_trap_status        = r_mstatus;
        w_trap_status[7]     = r_mstatus[3];
        w_trap_status[3]     = 1'b0;
        w_trap_status[12:11] = 2'b11;
        w_mret_status        = r_mstatus;
        w_mret_status[3]     = r_mstatus[7];
        w_mret_status[7]     = 1'b1;
        w_mret_status[12:11] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_take_exc) begin
                    w_next_state = c_trap_epc;
                end else if (w_take_mret) begin
                    w_next_state = c_mret_status;
                end else if (w_take_csr) begin
                    w_next_state = c_csr_wr;
                end
            end
            c_csr_wr:      w_next_state = c_idle;
            c_trap_epc:    w_next_state = c_trap_cause;
            c_trap_cause:  w_next_state = c_trap_tval;
            c_trap_tval:   w_next_state = c_trap_status;
            c_trap_status: w_next_state = c_idle;
            c_mret_status: w_next_state = c_idle;
            default:       w_next_state = c_idle;
        endcase
    end

    // Operand snapshots so the csrfile may change underneath a running sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_old     <= '0;
            r_new     <= '0;
            r_addr    <= '0;
            r_wen_ok  <= 1'b0;
            r_pc      <= '0;
            r_cause   <= '0;
            r_tval    <= '0;
            r_mstatus <= '0;
            r_mtvec   <= '0;
            r_mepc    <= '0;
        end else begin
            if (w_take_csr) begin
                r_old    <= csr_rdata;
                r_new    <= w_csr_new;
                r_addr   <= csr_addr;
                r_wen_ok <= w_csr_wen_ok;
            end
            if (w_take_exc) begin
                r_pc      <= exc_pc;
                r_cause   <= exc_cause;
                r_tval    <= exc_tval;
                r_mstatus <= mstatus_in;
                r_mtvec   <= mtvec_in;
            end
            if (w_take_mret) begin
                r_mstatus <= mstatus_in;
                r_mepc    <= mepc_in;
            end
        end
    end

    always_comb begin
        busy           = !w_idle;
        csr_raddr      = w_idle ? csr_addr : 12'h000;
        csr_wen        = 1'b0;
        csr_wa         = 12'h000;
        csr_wd         = '0;
        rd_valid       = 1'b0;
        rd_data        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            c_csr_wr: begin
                rd_valid = 1'b1;
                rd_data  = r_old;
                if (r_wen_ok) begin
                    csr_wen = 1'b1;
                    csr_wa  = r_addr;
                    csr_wd  = r_new;
                end
            end
            c_trap_epc: begin
                csr_wen = 1'b1;
                csr_wa  = c_addr_mepc;
                csr_wd  = r_pc & c_align_mask;
            end
            c_trap_cause: begin
                csr_wen = 1'b1;
                csr_wa  = c_addr_mcause;
                csr_wd  = r_cause;
            end
            c_trap_tval: begin
                csr_wen = 1'b1;
                csr_wa  = c_addr_mtval;
                csr_wd  = r_tval;
            end
            c_trap_status: begin
                csr_wen        = 1'b1;
                csr_wa         = c_addr_mstatus;
                csr_wd         = w_trap_status;
                redirect_valid = 1'b1;
                redirect_pc    = w_trap_target;
            end
            c_mret_status: begin
                csr_wen        = 1'b1;
                csr_wa         = c_addr_mstatus;
                csr_wd         = w_mret_status;
                redirect_valid = 1'b1;
                redirect_pc    = r_mepc;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
